phase_scheduler: RTL and testbench

//  Top-level sequencer for the systemizer datapath: runs NPH = L/N elimination phases back-to-back on one

---
 rtl/phase_scheduler.sv | 126 ++++++++++++
 tb/tb_phase_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_scheduler.sv
// Sequencer that runs L/N elimination phases back-to-back on a single phase instance,
// with a per-phase watchdog and ownership of the phase memory port while a run is active.
module phase_scheduler #(
  parameter  int N       = 4,
  parameter  int M       = 1,
  parameter  int L       = 8,
  parameter  int K       = 16,
  parameter  int TIMEOUT = 4096,
  // M<2 would give a zero-width data word; clamp so the ports stay legal
  localparam int CM      = ($clog2(M) < 1) ? 1 : $clog2(M),
  localparam int DW      = N * CM,
  localparam int NPH     = L / N,
  localparam int BW      = $clog2(K / N + 1),
  localparam int AW      = $clog2(L * K / N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic          fail_timeout,
  output logic [BW-1:0] phase_idx,
  input  logic          host_rd_en,
  input  logic [AW-1:0] host_rd_addr,
  output logic [DW-1:0] host_rd_data,
  input  logic          host_wr_en,
  input  logic [AW-1:0] host_wr_addr,
  input  logic [DW-1:0] host_wr_data,
  output logic          ph_start,
  output logic [BW-1:0] ph_start_block,
  output logic          ph_last_phase,
  input  logic          ph_done,
  input  logic          ph_fail,
  output logic          ph_rd_en,
  output logic [AW-1:0] ph_rd_addr,
  output logic          ph_wr_en,
  output logic [AW-1:0] ph_wr_addr,
  output logic [DW-1:0] ph_data_in,
  input  logic [DW-1:0] ph_data_out
);

  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WMAX = {WW{1'b1}};
  localparam logic [WW-1:0] WLIM = WW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
  localparam logic [BW-1:0] LAST = BW'(NPH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_DONE, S_FAIL
  } state_t;

  state_t        state;
  logic [WW-1:0] wdog;
  logic          is_last;

  assign is_last        = (phase_idx == LAST);
  assign ph_start_block = phase_idx;
  assign ph_last_phase  = is_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      phase_idx    <= '0;
      wdog         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      fail_timeout <= 1'b0;
      ph_start     <= 1'b0;
    end else begin
      ph_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (go) begin
            phase_idx    <= '0;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_timeout <= 1'b0;
            busy         <= 1'b1;
            ph_start     <= 1'b1;
            state        <= S_START;
          end
        end
        S_START: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wdog != WMAX) wdog <= wdog + 1'b1;
          // a failure report beats a completion in the same cycle
          if (ph_fail) begin
            fail         <= 1'b1;
            fail_timeout <= 1'b0;
            busy         <= 1'b0;
            state        <= S_FAIL;
          end else if (ph_done) begin
            if (is_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              phase_idx <= phase_idx + 1'b1;
              ph_start  <= 1'b1;
              state     <= S_START;
            end
          end else if (TIMEOUT != 0 && wdog == WLIM) begin
            fail         <= 1'b1;
            fail_timeout <= 1'b1;
            busy         <= 1'b0;
            state        <= S_FAIL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // host owns the memory strobes only between runs; address/data always pass through
  assign ph_rd_en     = host_rd_en & ~busy;
  assign ph_wr_en     = host_wr_en & ~busy;
  assign ph_rd_addr   = host_rd_addr;
  assign ph_wr_addr   = host_wr_addr;
  assign ph_data_in   = host_wr_data;
  assign host_rd_data = ph_data_out;

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: memory-mux vector table, directed multi-cycle sequences,
// and randomized runs checked against a per-phase outcome model.
module tb_phase_scheduler;
  localparam int N = 4, M = 2, L = 8, K = 16, TO = 64;
  localparam int DW = 4, BW = 3, AW = 5, NPH = 2;

  logic clk = 1'b0, rst = 1'b0, go = 1'b0, go0 = 1'b0;
  logic busy, done, fail, fail_timeout, ph_start, ph_last_phase;
  logic [BW-1:0] phase_idx, ph_start_block;
  logic host_rd_en = 1'b0, host_wr_en = 1'b0;
  logic [AW-1:0] host_rd_addr = '0, host_wr_addr = '0;
  logic [DW-1:0] host_wr_data = '0, ph_data_out = '0, host_rd_data;
  logic ph_done = 1'b0, ph_fail = 1'b0, ph_done0 = 1'b0;
  logic ph_rd_en, ph_wr_en;
  logic [AW-1:0] ph_rd_addr, ph_wr_addr;
  logic [DW-1:0] ph_data_in;

  logic busy0, done0, fail0, fto0, st0, lp0, rde0, wre0;
  logic [BW-1:0] idx0, blk0;
  logic [DW-1:0] hrd0, din0;
  logic [AW-1:0] ra0, wa0;

  phase_scheduler #(.N(N), .M(M), .L(L), .K(K), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .fail(fail),
    .fail_timeout(fail_timeout), .phase_idx(phase_idx),
    .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .ph_start(ph_start), .ph_start_block(ph_start_block), .ph_last_phase(ph_last_phase),
    .ph_done(ph_done), .ph_fail(ph_fail), .ph_rd_en(ph_rd_en), .ph_rd_addr(ph_rd_addr),
    .ph_wr_en(ph_wr_en), .ph_wr_addr(ph_wr_addr), .ph_data_in(ph_data_in),
    .ph_data_out(ph_data_out));

  phase_scheduler #(.N(N), .M(M), .L(L), .K(K), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .go(go0), .busy(busy0), .done(done0), .fail(fail0),
    .fail_timeout(fto0), .phase_idx(idx0),
    .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr), .host_rd_data(hrd0),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .ph_start(st0), .ph_start_block(blk0), .ph_last_phase(lp0),
    .ph_done(ph_done0), .ph_fail(1'b0), .ph_rd_en(rde0), .ph_rd_addr(ra0),
    .ph_wr_en(wre0), .ph_wr_addr(wa0), .ph_data_in(din0), .ph_data_out(ph_data_out));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0, errs = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit            in_run;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] mem_out;
    logic          x_rd_en;
    logic          x_wr_en;
  } mux_vec_t;
  mux_vec_t tbl[8];

  task automatic apply_vec(input mux_vec_t v);
    host_rd_en = v.rd_en; host_rd_addr = v.rd_addr;
    host_wr_en = v.wr_en; host_wr_addr = v.wr_addr; host_wr_data = v.wr_data;
    ph_data_out = v.mem_out;
    #1;
    chk("mux_rd_en", ph_rd_en, v.x_rd_en);
    chk("mux_wr_en", ph_wr_en, v.x_wr_en);
    chk("mux_rd_addr", ph_rd_addr, v.rd_addr);
    chk("mux_wr_addr", ph_wr_addr, v.wr_addr);
    chk("mux_wr_data", ph_data_in, v.wr_data);
    chk("mux_rd_data", host_rd_data, v.mem_out);
    host_rd_en = 1'b0; host_wr_en = 1'b0;
  endtask

  // results captured by run_phases
  int st_cnt, end_cyc;
  int st_cyc[4];
  logic [BW-1:0] blk[4];
  logic lastp[4];

  // mode per phase: 0 = ph_done, 1 = ph_fail, 2 = both in the same cycle
  task automatic run_phases(input int lat0, input int lat1, input int md0, input int md1,
                            input int extra);
    int lat[2]; int md[2]; int cnt, p, left; bit act, fin;
    lat[0] = lat0; lat[1] = lat1; md[0] = md0; md[1] = md1;
    st_cnt = 0; end_cyc = -1; act = 0; fin = 0; cnt = 0; p = 0; left = extra;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int k = 0; k < 400; k++) begin
      ph_done = 1'b0; ph_fail = 1'b0;
      if (!fin && (done || fail)) begin fin = 1; end_cyc = cyc; end
      if (ph_start) begin
        if (st_cnt < 4) begin
          st_cyc[st_cnt] = cyc; blk[st_cnt] = ph_start_block; lastp[st_cnt] = ph_last_phase;
        end
        p = st_cnt; st_cnt++; act = 1; cnt = 0;
      end else if (act) begin
        cnt++;
        if (p < 2 && cnt == lat[p]) begin
          if (md[p] != 0) ph_fail = 1'b1;
          if (md[p] != 1) ph_done = 1'b1;
          act = 0;
        end
      end
      if (fin) begin
        if (left == 0) break;
        left--;
      end
      @(negedge clk);
    end
    ph_done = 1'b0; ph_fail = 1'b0;
    chk("run_finished", fin, 1);
  endtask

  // Outcome model: walk phases in order; a phase answering after more than TO cycles
  // times out, otherwise its report (fail or done) decides.
  task automatic model(input int lat0, input int lat1, input int md0, input int md1,
                       output bit x_done, output bit x_fail, output bit x_to,
                       output int x_idx, output int x_starts);
    int lat[2]; int md[2];
    lat[0] = lat0; lat[1] = lat1; md[0] = md0; md[1] = md1;
    x_done = 1; x_fail = 0; x_to = 0; x_idx = NPH - 1; x_starts = NPH;
    for (int q = 0; q < NPH; q++) begin
      if (lat[q] > TO) begin
        x_done = 0; x_fail = 1; x_to = 1; x_idx = q; x_starts = q + 1; break;
      end else if (md[q] != 0) begin
        x_done = 0; x_fail = 1; x_to = 0; x_idx = q; x_starts = q + 1; break;
      end
    end
  endtask

  task automatic check_run(input string tag, input int lat0, input int lat1,
                           input int md0, input int md1);
    bit xd, xf, xt; int xi, xs;
    model(lat0, lat1, md0, md1, xd, xf, xt, xi, xs);
    run_phases(lat0, lat1, md0, md1, 12);
    chk({tag, "_done"}, done, xd);
    chk({tag, "_fail"}, fail, xf);
    chk({tag, "_fail_timeout"}, fail_timeout, xt);
    chk({tag, "_phase_idx"}, phase_idx, xi);
    chk({tag, "_starts"}, st_cnt, xs);
    chk({tag, "_busy"}, busy, 0);
    if (xs == 2) chk({tag, "_start_gap"}, st_cyc[1] - st_cyc[0], lat0 + 1);
  endtask

  initial begin
    int l0, l1, m0, m1;
    tbl[0] = '{0, 1'b1, 5'd3,  1'b0, 5'd0,  4'h0, 4'h5, 1'b1, 1'b0};
    tbl[1] = '{0, 1'b0, 5'd0,  1'b1, 5'd31, 4'hA, 4'h0, 1'b0, 1'b1};
    tbl[2] = '{0, 1'b1, 5'd17, 1'b1, 5'd9,  4'hF, 4'hC, 1'b1, 1'b1};
    tbl[3] = '{0, 1'b0, 5'd21, 1'b0, 5'd22, 4'h3, 4'h9, 1'b0, 1'b0};
    tbl[4] = '{1, 1'b1, 5'd4,  1'b0, 5'd0,  4'h0, 4'h6, 1'b0, 1'b0};
    tbl[5] = '{1, 1'b0, 5'd0,  1'b1, 5'd30, 4'hB, 4'h1, 1'b0, 1'b0};
    tbl[6] = '{1, 1'b1, 5'd31, 1'b1, 5'd1,  4'h7, 4'hE, 1'b0, 1'b0};
    tbl[7] = '{1, 1'b0, 5'd12, 1'b0, 5'd13, 4'h2, 4'h8, 1'b0, 1'b0};

    // reset held with go asserted
    go = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_timeout", fail_timeout, 0);
    chk("rst_ph_start", ph_start, 0);
    chk("rst_phase_idx", phase_idx, 0);
    host_wr_en = 1'b1; #1;
    chk("rst_wr_passthrough", ph_wr_en, 1);
    host_wr_en = 1'b0; go = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("idle_ph_start", ph_start, 0);
    for (int i = 0; i < 8; i++) if (!tbl[i].in_run) apply_vec(tbl[i]);

    // two clean phases, 10 cycles each
    run_phases(10, 10, 0, 0, 3);
    chk("t2_starts", st_cnt, 2);
    chk("t2_block0", blk[0], 0);
    chk("t2_block1", blk[1], 1);
    chk("t2_last0", lastp[0], 0);
    chk("t2_last1", lastp[1], 1);
    chk("t2_start_gap", st_cyc[1] - st_cyc[0], 11);
    chk("t2_done_cycle", end_cyc - st_cyc[1], 11);
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);

    // phase 1 reports failure
    run_phases(10, 10, 0, 1, 20);
    chk("t3_fail", fail, 1);
    chk("t3_fail_timeout", fail_timeout, 0);
    chk("t3_phase_idx", phase_idx, 1);
    chk("t3_starts", st_cnt, 2);
    chk("t3_done", done, 0);

    // go clears fail; then nobody answers -> watchdog
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("t5_fail_cleared", fail, 0);
    chk("t5_busy", busy, 1);
    chk("t5_ph_start", ph_start, 1);
    repeat (64) @(negedge clk);
    chk("t5_no_fail_at_64", fail, 0);
    @(negedge clk);
    chk("t5_fail_at_65", fail, 1);
    chk("t5_fail_timeout", fail_timeout, 1);
    chk("t5_phase_idx", phase_idx, 0);
    chk("t5_busy_after", busy, 0);

    // done and fail together in phase 0
    run_phases(7, 7, 2, 0, 20);
    chk("t4_fail", fail, 1);
    chk("t4_fail_timeout", fail_timeout, 0);
    chk("t4_phase_idx", phase_idx, 0);
    chk("t4_starts", st_cnt, 1);

    // host strobes blocked while busy, go ignored, async reset mid-WAIT
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) if (tbl[i].in_run) apply_vec(tbl[i]);
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("t6_go_ignored_start", ph_start, 0);
    chk("t6_go_ignored_busy", busy, 1);
    @(negedge clk);
    chk("t6_go_ignored_start2", ph_start, 0);
    rst = 1'b0; #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_idx", phase_idx, 0);
    host_rd_en = 1'b1; #1;
    chk("t6_rst_rd_en", ph_rd_en, 1);
    host_rd_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("t6_idle_after_rst", ph_start, 0);

    // watchdog boundaries
    check_run("b64", 64, 64, 0, 0);
    check_run("b65", 65, 10, 0, 0);
    check_run("b1", 1, 65, 0, 0);

    // watchdog disabled
    @(negedge clk); go0 = 1'b1;
    @(negedge clk); go0 = 1'b0;
    repeat (300) @(negedge clk);
    chk("to0_no_fail", fail0, 0);
    chk("to0_busy", busy0, 1);
    ph_done0 = 1'b1;
    @(negedge clk); ph_done0 = 1'b0;
    @(negedge clk);
    chk("to0_phase1", idx0, 1);

    // randomized runs
    for (int r = 0; r < 30; r++) begin
      l0 = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 40);
      l1 = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 40);
      m0 = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
      m1 = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
      check_run("rnd", l0, l1, m0, m1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end
endmodule
